matvec_sequencer: RTL and testbench

//  Initiator side of the 8-wide dot_product engine. Holds an N_ROWS x 8 weight

---
 rtl/matvec_sequencer_if.sv | 47 ++++
 rtl/matvec_sequencer.sv | 156 +++++++++++++++
 tb/tb_matvec_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matvec_sequencer_if.sv
// Host and dot-product-engine signal bundle for matvec_sequencer.
// The bias-write signals exist only when MATVEC_BIAS_EN is defined.
interface matvec_sequencer_if #(
  parameter int W      = 16,
  parameter int N_ROWS = 8,
  parameter int RW     = 3
);
  logic                     w_we;
  logic [RW-1:0]            w_row;
  logic [2:0]               w_col;
  logic [W-1:0]             w_data;
  logic [7:0][W-1:0]        x;
  logic                     start;
  logic                     busy;
  logic                     done;
  logic [N_ROWS-1:0][W-1:0] y;
  logic [7:0][W-1:0]        dp_a;
  logic [7:0][W-1:0]        dp_b;
  logic                     dp_rst;
  logic [W-1:0]             dp_out;
  logic                     dp_valid;
`ifdef MATVEC_BIAS_EN
  logic                     b_we;
  logic [RW-1:0]            b_row;
  logic [W-1:0]             b_data;

  modport slave (
    input  w_we, w_row, w_col, w_data, x, start, dp_out, dp_valid,
    input  b_we, b_row, b_data,
    output busy, done, y, dp_a, dp_b, dp_rst
  );
  modport master (
    output w_we, w_row, w_col, w_data, x, start, dp_out, dp_valid,
    output b_we, b_row, b_data,
    input  busy, done, y, dp_a, dp_b, dp_rst
  );
`else
  modport slave (
    input  w_we, w_row, w_col, w_data, x, start, dp_out, dp_valid,
    output busy, done, y, dp_a, dp_b, dp_rst
  );
  modport master (
    output w_we, w_row, w_col, w_data, x, start, dp_out, dp_valid,
    input  busy, done, y, dp_a, dp_b, dp_rst
  );
`endif
endinterface

// File: rtl/matvec_sequencer.sv
// Matrix-vector sequencer driving an 8-wide dot-product engine, one row per pass.
// Optional per-row saturating bias on capture: define MATVEC_BIAS_EN.
module matvec_sequencer #(
  parameter int W      = 16,
  parameter int N_ROWS = 8,
  parameter int RW     = 3
) (
  input  logic               clk,
  input  logic               rst,
  matvec_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KICK = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                         state_r;
  state_t                         state_s;
  logic [RW-1:0]                  row_r;
  logic [N_ROWS-1:0][7:0][W-1:0]  wgt_r;
  logic [7:0][W-1:0]              x_r;
  logic [7:0][W-1:0]              dp_a_r;
  logic [N_ROWS-1:0][W-1:0]       y_r;
  logic                           busy_r;
  logic                           done_r;
  logic                           dp_rst_r;
  logic                           capture_s;
  logic                           last_row_s;
  logic                           host_wr_ok_s;
  logic [W-1:0]                   y_new_s;

  assign capture_s    = (state_r == ST_WAIT) && bus.dp_valid;
  assign last_row_s   = (int'(row_r) == (N_ROWS - 1));
  assign host_wr_ok_s = !busy_r;

`ifdef MATVEC_BIAS_EN
  logic [N_ROWS-1:0][W-1:0] bias_r;

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {a[W-1], a} + {b[W-1], b};
    if (sum[W] != sum[W-1]) begin
      sat_add = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sat_add = sum[W-1:0];
    end
  endfunction

  // Bias bank, frozen while a run is in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias_r <= '0;
    end else if (bus.b_we && host_wr_ok_s && (int'(bus.b_row) < N_ROWS)) begin
      bias_r[bus.b_row] <= bus.b_data;
    end
  end

  // Capture value: engine result plus row bias, clamped to the W-bit range
  always_comb begin
    y_new_s = sat_add(bus.dp_out, bias_r[row_r]);
  end
`else
  // Capture value: engine result passed through untouched
  always_comb begin
    y_new_s = bus.dp_out;
  end
`endif

  // Weight bank, frozen while a run is in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wgt_r <= '0;
    end else if (bus.w_we && host_wr_ok_s && (int'(bus.w_row) < N_ROWS)) begin
      wgt_r[bus.w_row][bus.w_col] <= bus.w_data;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state; no timeout while waiting on the engine
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_KICK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_KICK: state_s = ST_WAIT;
      ST_WAIT: begin
        if (bus.dp_valid) begin
          if (last_row_s) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_KICK;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Registered outputs, operand latches, row counter and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dp_rst_r <= 1'b1;
      row_r    <= '0;
      x_r      <= '0;
      dp_a_r   <= '0;
      y_r      <= '0;
    end else begin
      busy_r   <= (state_s != ST_IDLE);
      done_r   <= (state_s == ST_DONE);
      // Engine only leaves reset during WAIT, so each row restarts its count
      dp_rst_r <= (state_s != ST_WAIT);
      if ((state_r == ST_IDLE) && bus.start) begin
        x_r   <= bus.x;
        row_r <= '0;
      end
      if (state_r == ST_KICK) begin
        dp_a_r <= wgt_r[row_r];
      end
      if (capture_s) begin
        y_r[row_r] <= y_new_s;
        if (!last_row_s) begin
          row_r <= row_r + RW'(1);
        end
      end
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.dp_rst = dp_rst_r;
  assign bus.dp_a   = dp_a_r;
  assign bus.dp_b   = x_r;
  assign bus.y      = y_r;

endmodule

// File: tb/tb_matvec_sequencer.sv
// Scoreboard bench for matvec_sequencer with a 7-cycle dot-product engine model
// and a behavioural matrix-vector reference; define MATVEC_BIAS_EN for bias runs.
module tb_matvec_sequencer;

  localparam int W    = 16;
  localparam int NR   = 8;
  localparam int RW   = 3;
  localparam int ROWT = 9 * NR + 1;

  typedef struct {
    logic [NR-1:0][W-1:0] y;
    longint               start_cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint cyc = 0;
  int     n_chk = 0;
  int     n_pass = 0;
  exp_t   exp_q[$];

  logic signed [W-1:0] ref_w [NR][8];
  logic signed [W-1:0] ref_b [NR];

  logic         eng_valid;
  logic [W-1:0] eng_out;
  int           eng_cnt;
  logic         eng_rst;

  matvec_sequencer_if #(.W(W), .N_ROWS(NR), .RW(RW)) bus();

  matvec_sequencer #(.W(W), .N_ROWS(NR), .RW(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign eng_rst      = bus.dp_rst;
  assign bus.dp_valid = eng_valid;
  assign bus.dp_out   = eng_out;

  function automatic logic [W-1:0] eng_dot(input logic [7:0][W-1:0] a, input logic [7:0][W-1:0] b);
    longint     acc;
    logic [63:0] v;
    acc = 0;
    for (int i = 0; i < 8; i++) acc += longint'($signed(a[i])) * longint'($signed(b[i]));
    v = acc;
    return v[27:12];
  endfunction

  // Engine: valid on the 7th clock out of reset, held until dp_rst
  always @(posedge clk or posedge eng_rst) begin
    if (eng_rst) begin
      eng_cnt   <= 0;
      eng_valid <= 1'b0;
      eng_out   <= '0;
    end else if (!eng_valid) begin
      if (eng_cnt == 6) begin
        eng_valid <= 1'b1;
        eng_out   <= eng_dot(bus.dp_a, bus.dp_b);
      end
      eng_cnt <= eng_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: y[r] = sat(floor(sum_c W[r][c]*x[c] / 4096) mod 2^16 + bias[r])
  function automatic logic [W-1:0] ref_row(input int r, input logic [7:0][W-1:0] xv);
    longint      acc;
    longint      q;
    longint      s;
    logic [63:0] v;
    acc = 0;
    for (int c = 0; c < 8; c++) acc += longint'(ref_w[r][c]) * longint'($signed(xv[c]));
    q = acc >>> 12;
    v = q;
    s = longint'($signed(v[15:0])) + longint'(ref_b[r]);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    v = s;
    return v[15:0];
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NR; r++) begin
      ref_b[r] = '0;
      for (int c = 0; c < 8; c++) ref_w[r][c] = '0;
    end
  endtask

  task automatic write_w(input int r, input int c, input logic [W-1:0] d);
    bus.w_we = 1'b1; bus.w_row = RW'(r); bus.w_col = 3'(c); bus.w_data = d;
    ref_w[r][c] = d;
    @(negedge clk);
    bus.w_we = 1'b0;
  endtask

`ifdef MATVEC_BIAS_EN
  task automatic write_b(input int r, input logic [W-1:0] d);
    bus.b_we = 1'b1; bus.b_row = RW'(r); bus.b_data = d;
    ref_b[r] = d;
    @(negedge clk);
    bus.b_we = 1'b0;
  endtask
`endif

  task automatic load_const(input logic [W-1:0] d);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < 8; c++) write_w(r, c, d);
  endtask

  // mode 0: plain run; 1: start pulses and writes mid-run; 2: rst 20 cycles in
  task automatic run_mv(input logic [7:0][W-1:0] xv, input int mode);
    exp_t e;
    bit   seen;
    bit   aborted;
    bit   busy_seen;
    seen = 1'b0; aborted = 1'b0;
    for (int r = 0; r < NR; r++) e.y[r] = ref_row(r, xv);
    e.start_cyc = cyc;
    exp_q.push_back(e);
    bus.x = xv; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) bus.x[i] = W'($urandom);
    for (int i = 0; i < 2 * ROWT && !seen; i++) begin
      @(negedge clk);
      if (mode == 1) begin
        if (i >= 30 && i < 38) begin
          bus.w_we = 1'b1; bus.w_row = RW'(i - 30); bus.w_col = 3'(i % 8); bus.w_data = 16'h7FFF;
        end else begin
          bus.w_we = 1'b0;
        end
        bus.start = (i == 40);
      end
      if (mode == 2 && i == 20) begin
        #2 rst = 1'b1;
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_dp_rst", bus.dp_rst, 1'b1);
        check("rst_y_clear", bus.y, '0);
        exp_q.delete();
        model_clear();
        @(negedge clk);
        #2 rst = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (bus.done) begin
        seen = 1'b1;
        if (mode == 1) bus.start = 1'b1;
      end
    end
    if (!aborted) begin
      check("done_seen", seen, 1'b1);
      @(negedge clk);
      bus.start = 1'b0;
    end
    if (mode == 1) begin
      busy_seen = 1'b0;
      repeat (100) begin
        @(negedge clk);
        if (bus.busy) busy_seen = 1'b1;
      end
      check("no_restart", busy_seen, 1'b0);
    end
  endtask

  // Monitor: compares results, latency and busy width whenever done pulses
  initial begin
    int   busy_cnt;
    bit   prev_done;
    exp_t e;
    busy_cnt = 0; prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0; prev_done = 1'b0;
      end else begin
        if (prev_done) begin
          check("done_one_cycle", bus.done, 1'b0);
          check("idle_after_done", bus.busy, 1'b0);
        end
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            for (int r = 0; r < NR; r++) check($sformatf("y[%0d]", r), bus.y[r], e.y[r]);
            check("done_latency", cyc - e.start_cyc, ROWT);
            check("busy_cycles", busy_cnt, 9 * NR);
          end
          busy_cnt = 0;
        end else if (bus.busy) begin
          busy_cnt++;
        end
        prev_done = bus.done;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0][W-1:0] xv;
    bus.w_we = 1'b0; bus.w_row = '0; bus.w_col = '0; bus.w_data = '0;
    bus.x = '0; bus.start = 1'b0;
`ifdef MATVEC_BIAS_EN
    bus.b_we = 1'b0; bus.b_row = '0; bus.b_data = '0;
`endif
    model_clear();
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_dp_rst", bus.dp_rst, 1'b1);
    check("reset_y", bus.y, '0);
    check("reset_dp_b", bus.dp_b, '0);
    #2 rst = 1'b0;
    @(negedge clk);

    // Diagonal identity: y equals x
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < 8; c++) write_w(r, c, (r == c) ? 16'h1000 : 16'h0000);
    for (int i = 0; i < 8; i++) xv[i] = W'(16'h0100 * (i + 1));
    run_mv(xv, 0);
    for (int r = 0; r < NR; r++) check("diag_y_eq_x", bus.y[r], xv[r]);

    // Uniform positive and negative weights
    load_const(16'h1000);
    for (int i = 0; i < 8; i++) xv[i] = 16'h0800;
    run_mv(xv, 0);
    check("ones_y0", bus.y[0], 16'h4000);
    load_const(16'hF000);
    for (int i = 0; i < 8; i++) xv[i] = 16'h0400;
    run_mv(xv, 0);
    check("neg_y7", bus.y[7], 16'hE000);

    // Mid-run start/writes ignored, then a clean rerun
    load_const(16'h1000);
    for (int i = 0; i < 8; i++) xv[i] = 16'h0800;
    run_mv(xv, 1);
    run_mv(xv, 0);

    // Reset mid-run, then reload and run again
    run_mv(xv, 2);
    @(negedge clk);
    load_const(16'h1000);
    run_mv(xv, 0);

`ifdef MATVEC_BIAS_EN
    write_b(0, 16'h7000);
    write_b(1, 16'hC000);
`endif
    run_mv(xv, 0);

    // Randomized weights and vectors
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < 8; c++) write_w(r, c, W'($urandom));
      for (int i = 0; i < 8; i++) xv[i] = W'($urandom_range(0, 16'hFFFF));
      run_mv(xv, 0);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
